seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits; legal range 1..16.
REQ-002 Parameter PRESCALE, default 100000, clk cycles per digit slot; PRESCALE >= 2.
REQ-003 Parameter DEAD, default 2, anti-ghosting cycles at slot start with all anodes off; 0 <= DEAD < PRESCALE.
REQ-004 Parameter BLINK_DIV, default 64, full scan frames per blink half-period; >= 1.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-007 load  in  1  capture strobe for digits_in, en_in, dp_in, blink_in.
REQ-008 digits_in  in  4*N_DIGITS  hex value of digit i at [4i+3:4i]; digit 0 is rightmost.
REQ-009 en_in  in  N_DIGITS  per-digit enable, 1 = digit may light.
REQ-010 dp_in  in  N_DIGITS  per-digit decimal point, 1 = lit.
REQ-011 blink_in  in  N_DIGITS  per-digit blink request.
REQ-012 lzb_en  in  1  leading-zero blanking enable, live (not captured).
REQ-013 anode_n  out  N_DIGITS  active-low digit select, at most one bit low.
REQ-014 seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-015 dp_n  out  1  active-low decimal point.
REQ-016 bcd  out  4  value of currently scanned digit.
REQ-017 frame_tick  out  1  one-cycle pulse per completed scan frame.

Function
REQ-018 Shadow registers SHALL capture digits_in/en_in/dp_in/blink_in on any edge with load=1; display logic SHALL use only shadow values.
REQ-019 Prescaler pre SHALL count 0..PRESCALE-1 and wrap; slot advance occurs on the edge where pre=PRESCALE-1.
REQ-020 Scan index idx SHALL increment on slot advance, wrapping N_DIGITS-1 -> 0; N_DIGITS=1 keeps idx=0.
REQ-021 frame_tick SHALL be 1 for exactly the cycle following the edge where idx wraps to 0.
REQ-022 Frame counter SHALL count frames 0..BLINK_DIV-1; on its wrap blink_phase SHALL toggle.
REQ-023 Leading-zero blank of digit i (i>0) SHALL hold when lzb_en=1 and shadow digits i..N_DIGITS-1 are all 0; digit 0 is never LZ-blanked.
REQ-024 Digit idx visible iff en_sh[idx]=1, not (blink_sh[idx]=1 and blink_phase=0), not LZ-blanked, and pre >= DEAD.
REQ-025 All outputs SHALL be registered, computed from current-cycle state (1-cycle latency from idx/pre/shadow change).
REQ-026 Visible: anode_n bit idx low, others high; seg_n = hex decode of digit; dp_n = ~dp_sh[idx].
REQ-027 Not visible: anode_n all 1, seg_n = 7'h7F, dp_n = 1; bcd still carries the digit value.
REQ-028 Decode SHALL cover 0-F, e.g. 0->7'b1000000, 1->7'b1111001, 8->7'b0000000, A->7'b0001000, F->7'b0001110.
REQ-029 load mid-slot SHALL take effect on outputs the cycle after capture, without disturbing pre/idx.

Reset
REQ-030 On reset=1: pre=0, idx=0, frame counter=0, blink_phase=1, shadows all 0, anode_n all 1, seg_n=7'h7F, dp_n=1, bcd=0, frame_tick=0.
REQ-031 Reset asserted mid-slot SHALL blank outputs without waiting for clk; scanning restarts at idx=0, pre=0 on the first edge after release.

Verification (N_DIGITS=4, PRESCALE=4, DEAD=1, BLINK_DIV=2)
REQ-032 Load digits 16'h4321, en=4'hF -> anode_n steps 1110,1101,1011,0111 with seg_n decoding 1,2,3,4; each slot anodes all-1 for 1 cycle then selected for 3; frame_tick every 16 cycles.
REQ-033 digits 16'h0070, lzb_en=1, en=4'hF -> digits 3 and 2 dark; digits 1 (7) and 0 (0, seg_n=7'b1000000) lit; lzb_en=0 -> all four lit.
REQ-034 blink_in=4'b0001 -> digit 0 lit 2 frames, dark 2 frames, repeating; other digits steady.
REQ-035 en_in=4'b1010, dp_in=4'b0010 -> only digits 1 and 3 light; dp_n=0 only during digit 1 visible cycles.
REQ-036 Reset pulse mid-slot at idx=2 -> outputs at reset values asynchronously; after release, first visible digit is idx 0 at cycle DEAD+1.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if: capture/control inputs and multiplexed display outputs of the scan controller
interface seg_scan_if #(
    parameter int N_DIGITS = 8
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   digits_in;
    logic [N_DIGITS-1:0]     en_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     blink_in;
    logic                    lzb_en;
    logic [N_DIGITS-1:0]     anode_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [3:0]              bcd;
    logic                    frame_tick;

    modport master (
        output load, digits_in, en_in, dp_in, blink_in, lzb_en,
        input  anode_n, seg_n, dp_n, bcd, frame_tick
    );

    modport slave (
        input  load, digits_in, en_in, dp_in, blink_in, lzb_en,
        output anode_n, seg_n, dp_n, bcd, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scanner with dead time, blinking and leading-zero blanking
module seg_scan_ctrl #(
    parameter int N_DIGITS  = 8,
    parameter int PRESCALE  = 100000,
    parameter int DEAD      = 2,
    parameter int BLINK_DIV = 64
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam int FW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [FW-1:0]       r_frame;
    logic                r_phase;
    logic [3:0]          r_dig [N_DIGITS];
    logic [N_DIGITS-1:0] r_en;
    logic [N_DIGITS-1:0] r_dp;
    logic [N_DIGITS-1:0] r_blink;
    logic [N_DIGITS-1:0] r_anode_n;
    logic [6:0]          r_seg_n;
    logic                r_dp_n;
    logic [3:0]          r_bcd;
    logic                r_tick;

    logic                w_adv;
    logic                w_wrap;
    logic [N_DIGITS-1:0] w_zero_hi;
    logic [3:0]          w_cur;
    logic                w_lz;
    logic                w_vis;

    function automatic logic [6:0] f_hex(input logic [3:0] v);
        case (v)
            4'h0: f_hex = 7'b1000000;
            4'h1: f_hex = 7'b1111001;
            4'h2: f_hex = 7'b0100100;
            4'h3: f_hex = 7'b0110000;
            4'h4: f_hex = 7'b0011001;
            4'h5: f_hex = 7'b0010010;
            4'h6: f_hex = 7'b0000010;
            4'h7: f_hex = 7'b1111000;
            4'h8: f_hex = 7'b0000000;
            4'h9: f_hex = 7'b0010000;
            4'hA: f_hex = 7'b0001000;
            4'hB: f_hex = 7'b0000011;
            4'hC: f_hex = 7'b1000110;
            4'hD: f_hex = 7'b0100001;
            4'hE: f_hex = 7'b0000110;
            default: f_hex = 7'b0001110;
        endcase
    endfunction

    assign w_adv  = r_pre == PW'(PRESCALE - 1);
    assign w_wrap = w_adv && r_idx == IW'(N_DIGITS - 1);
    assign w_cur  = r_dig[r_idx];
    assign w_lz   = bus.lzb_en && r_idx != '0 && w_zero_hi[r_idx];
    assign w_vis  = r_en[r_idx] && !(r_blink[r_idx] && !r_phase) && !w_lz && r_pre >= PW'(DEAD);

    // w_zero_hi[i] is set when shadow digits i..N_DIGITS-1 are all zero
    always_comb begin
        w_zero_hi = '0;
        w_zero_hi[N_DIGITS-1] = r_dig[N_DIGITS-1] == 4'h0;
        for (int i = N_DIGITS - 2; i >= 0; i--)
            w_zero_hi[i] = w_zero_hi[i+1] && r_dig[i] == 4'h0;
    end

    // shadow registers: display only ever sees values captured on load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++)
                r_dig[i] <= 4'h0;
            r_en    <= '0;
            r_dp    <= '0;
            r_blink <= '0;
        end else if (bus.load) begin
            for (int i = 0; i < N_DIGITS; i++)
                r_dig[i] <= bus.digits_in[4*i +: 4];
            r_en    <= bus.en_in;
            r_dp    <= bus.dp_in;
            r_blink <= bus.blink_in;
        end
    end

    // slot prescaler, scan index, frame counter and blink phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_phase <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_pre  <= w_adv ? '0 : r_pre + 1'b1;
            r_tick <= w_wrap;
            if (w_adv)
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            if (w_wrap) begin
                r_frame <= r_frame == FW'(BLINK_DIV - 1) ? '0 : r_frame + 1'b1;
                if (r_frame == FW'(BLINK_DIV - 1))
                    r_phase <= ~r_phase;
            end
        end
    end

    // registered display drive derived from the current scan state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_anode_n <= '1;
            r_seg_n   <= 7'h7F;
            r_dp_n    <= 1'b1;
            r_bcd     <= 4'h0;
        end else begin
            r_anode_n <= w_vis ? ~(N_DIGITS'(1) << r_idx) : '1;
            r_seg_n   <= w_vis ? f_hex(w_cur) : 7'h7F;
            r_dp_n    <= w_vis ? ~r_dp[r_idx] : 1'b1;
            r_bcd     <= w_cur;
        end
    end

    assign bus.anode_n    = r_anode_n;
    assign bus.seg_n      = r_seg_n;
    assign bus.dp_n       = r_dp_n;
    assign bus.bcd        = r_bcd;
    assign bus.frame_tick = r_tick;
endmodule
